aes_io_sequencer: RTL and testbench

- Byte-serial front end and sequencer for the 128-bit AES encryption core behind the TinyTapeout pin wrapper.
- Assembles the key and plaintext from 8-bit pin writes and launches the core.
- Waits for completion with a watchdog, then streams the 16-byte ciphertext back out one byte per read strobe.
- Sits between the ui_in/uio_in/uo_out pin decode and the AES round datapath.

---
 rtl/aes_io_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_aes_io_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_io_sequencer.sv
// Byte-serial front end for the AES-128 core: assembles key and plaintext
// from pin writes, launches the core, guards the wait with a watchdog and
// streams the ciphertext back out one byte per read strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accept key/plaintext bytes, launch when both are full
// RUN   | core running, watchdog armed, waiting for core_done
// OUT   | ciphertext captured, one byte presented per rd_next
// ERR   | watchdog expired, held until clr
module aes_io_sequencer #(
  parameter int NBYTES  = 16,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic                start,
  input  logic                rd_next,
  input  logic                clr,
  output logic [8*NBYTES-1:0] key,
  output logic [8*NBYTES-1:0] block,
  output logic                core_start,
  input  logic                core_done,
  input  logic [8*NBYTES-1:0] core_result,
  output logic [7:0]          data_out,
  output logic                out_valid,
  output logic                busy,
  output logic                key_full,
  output logic                txt_full,
  output logic                err
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] WD_LOAD   = TW'(TIMEOUT);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]             state;
  logic [CW-1:0]          key_cnt;
  logic [CW-1:0]          txt_cnt;
  logic [CW-1:0]          rd_ptr;
  logic [TW-1:0]          wd_cnt;
  logic [8*NBYTES-1:0]    result_q;

  logic in_load;
  logic key_wr;
  logic txt_wr;
  logic launch;

  // Writes and launch are only honoured in LOAD and never alongside clr;
  // launch looks at the flags as they stood before this cycle's write.
  always_comb begin
    in_load = (state == ST_LOAD) && !clr;
    key_wr  = in_load && wr_en && !wr_sel;
    txt_wr  = in_load && wr_en && wr_sel;
    launch  = in_load && start && key_full && txt_full;
  end

  // Sequencer state, byte counters, full flags, read pointer and watchdog.
  // The watchdog counts down from TIMEOUT, so reaching zero marks the
  // TIMEOUT-th cycle without core_done since launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      key_cnt    <= '0;
      txt_cnt    <= '0;
      key_full   <= 1'b0;
      txt_full   <= 1'b0;
      rd_ptr     <= '0;
      wd_cnt     <= '0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      if (clr) begin
        state    <= ST_LOAD;
        key_cnt  <= '0;
        txt_cnt  <= '0;
        key_full <= 1'b0;
        txt_full <= 1'b0;
        rd_ptr   <= '0;
        wd_cnt   <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (key_wr) begin
              if (key_cnt == LAST_BYTE) begin
                key_cnt  <= '0;
                key_full <= 1'b1;
              end else begin
                key_cnt <= key_cnt + 1'b1;
              end
            end
            if (txt_wr) begin
              if (txt_cnt == LAST_BYTE) begin
                txt_cnt  <= '0;
                txt_full <= 1'b1;
              end else begin
                txt_cnt <= txt_cnt + 1'b1;
              end
            end
            if (launch) begin
              state      <= ST_RUN;
              core_start <= 1'b1;
              wd_cnt     <= WD_LOAD;
            end
          end
          ST_RUN: begin
            if (core_done) begin
              state  <= ST_OUT;
              rd_ptr <= '0;
            end else if (wd_cnt == '0) begin
              state <= ST_ERR;
            end else begin
              wd_cnt <= wd_cnt - 1'b1;
            end
          end
          ST_OUT: begin
            if (rd_next) begin
              if (rd_ptr == LAST_BYTE) begin
                state    <= ST_LOAD;
                rd_ptr   <= '0;
                txt_full <= 1'b0;
                txt_cnt  <= '0;
              end else begin
                rd_ptr <= rd_ptr + 1'b1;
              end
            end
          end
          ST_ERR: begin
            state <= ST_ERR;
          end
          default: begin
            state <= ST_LOAD;
          end
        endcase
      end
    end
  end

  // Key/plaintext byte registers (MSB byte first) and ciphertext capture.
  // clr leaves key and block contents alone; only the flags force a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key      <= '0;
      block    <= '0;
      result_q <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (key_wr && (key_cnt == CW'(i))) begin
          key[8*(NBYTES-1-i) +: 8] <= data_in;
        end
        if (txt_wr && (txt_cnt == CW'(i))) begin
          block[8*(NBYTES-1-i) +: 8] <= data_in;
        end
      end
      if ((state == ST_RUN) && core_done && !clr) begin
        result_q <= core_result;
      end
    end
  end

  // Present the selected ciphertext byte only while in OUT, zero otherwise.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if ((state == ST_OUT) && (rd_ptr == CW'(i))) begin
        data_out = result_q[8*(NBYTES-1-i) +: 8];
      end
    end
  end

  assign out_valid = (state == ST_OUT);
  assign busy      = (state == ST_RUN);
  assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Scoreboard bench for aes_io_sequencer: stimulus pushes expected launches
// and ciphertext bytes into queues, a negedge monitor pops and compares.
module tb_aes_io_sequencer;

  localparam int NBYTES  = 16;
  localparam int TIMEOUT = 255;
  localparam int TW      = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   data_in = '0;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic         start = 1'b0;
  logic         rd_next = 1'b0;
  logic         clr = 1'b0;
  logic [127:0] key;
  logic [127:0] block;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic [7:0]   data_out;
  logic         out_valid;
  logic         busy;
  logic         key_full;
  logic         txt_full;
  logic         err;

  aes_io_sequencer #(.NBYTES(NBYTES), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .wr_sel(wr_sel),
    .start(start), .rd_next(rd_next), .clr(clr), .key(key), .block(block),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .key_full(key_full),
    .txt_full(txt_full), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] launch_q[$];
  logic [7:0]   byte_q[$];
  logic [255:0] mon_launch;
  logic [7:0]   mon_byte;

  // Reference model: byte arrays in write order plus fill counts.
  logic [7:0] m_key[NBYTES];
  logic [7:0] m_txt[NBYTES];
  int         m_kcnt, m_tcnt;
  bit         m_kfull, m_tfull;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset_all();
    for (int i = 0; i < NBYTES; i++) begin
      m_key[i] = '0;
      m_txt[i] = '0;
    end
    m_kcnt = 0; m_tcnt = 0; m_kfull = 0; m_tfull = 0;
  endtask

  task automatic m_clear_flags();
    m_kcnt = 0; m_tcnt = 0; m_kfull = 0; m_tfull = 0;
  endtask

  task automatic m_write(input bit sel, input logic [7:0] b);
    if (!sel) begin
      m_key[m_kcnt] = b;
      m_kcnt++;
      if (m_kcnt == NBYTES) begin m_kcnt = 0; m_kfull = 1; end
    end else begin
      m_txt[m_tcnt] = b;
      m_tcnt++;
      if (m_tcnt == NBYTES) begin m_tcnt = 0; m_tfull = 1; end
    end
  endtask

  function automatic logic [127:0] m_key_vec();
    logic [127:0] v;
    for (int i = 0; i < NBYTES; i++) v[127-8*i -: 8] = m_key[i];
    return v;
  endfunction

  function automatic logic [127:0] m_txt_vec();
    logic [127:0] v;
    for (int i = 0; i < NBYTES; i++) v[127-8*i -: 8] = m_txt[i];
    return v;
  endfunction

  // Monitor: compare launches and read-out bytes as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) begin
        if (launch_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_launch: actual=1 required=0");
        end else begin
          mon_launch = launch_q.pop_front();
          check("launch_key_block", {key, block}, mon_launch);
        end
      end
      if (out_valid && rd_next) begin
        if (byte_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_byte: actual=%0h required=none", data_out);
        end else begin
          mon_byte = byte_q.pop_front();
          check("cipher_byte", 256'(data_out), 256'(mon_byte));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [7:0] b);
    wr_en = 1'b1; wr_sel = sel; data_in = b;
    tick();
    wr_en = 1'b0;
    m_write(sel, b);
  endtask

  task automatic load_rand(input bit sel, input int n);
    for (int i = 0; i < n; i++) wr(sel, 8'($urandom));
  endtask

  // Start request; the model decides whether a launch must follow.
  task automatic do_start();
    bit exp;
    exp = m_kfull && m_tfull;
    if (exp) launch_q.push_back({m_key_vec(), m_txt_vec()});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("core_start_after_start", 256'(core_start), 256'(exp));
    check("busy_after_start", 256'(busy), 256'(exp));
  endtask

  // Write and start together: start is judged on the pre-write flags.
  task automatic wr_start(input bit sel, input logic [7:0] b);
    bit exp;
    exp = m_kfull && m_tfull;
    if (exp) launch_q.push_back({m_key_vec(), m_txt_vec()});
    wr_en = 1'b1; wr_sel = sel; data_in = b; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    m_write(sel, b);
    check("wr_start_launch", 256'(core_start), 256'(exp));
  endtask

  // Called in the core_start cycle; core_done is driven in cycle lat.
  task automatic run_core(input int lat, input logic [127:0] res);
    for (int k = 0; k < lat; k++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_sel = 1'($urandom_range(0, 1));
      data_in = 8'($urandom); rd_next = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      tick();
      if (k == 0) check("core_start_one_cycle", 256'(core_start), 256'(0));
    end
    wr_en = 1'b0; rd_next = 1'b0; start = 1'b0;
    check("busy_before_done", 256'(busy), 256'(1));
    for (int i = 0; i < NBYTES; i++) byte_q.push_back(res[127-8*i -: 8]);
    core_done = 1'b1; core_result = res;
    tick();
    core_done = 1'b0; core_result = {4{$urandom}};
    check("out_valid_after_done", 256'({out_valid, busy, err}), 256'(3'b100));
    check("first_byte", 256'(data_out), 256'(res[127:120]));
    check("key_block_held_in_run", {key, block}, {m_key_vec(), m_txt_vec()});
  endtask

  task automatic read_bytes(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      rd_next = 1'b1;
      tick();
      rd_next = 1'b0;
    end
  endtask

  task automatic read_all(input int max_gap);
    read_bytes(NBYTES, max_gap);
    m_tfull = 0; m_tcnt = 0;
    check("bytes_drained", 256'(byte_q.size()), 256'(0));
    check("load_after_read", 256'({out_valid, busy, data_out}), 256'(0));
    check("flags_after_read", 256'({key_full, txt_full}), 256'({m_kfull, m_tfull}));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clear_flags();
    check("after_clr", 256'({err, key_full, txt_full, out_valid, busy, core_start}), 256'(0));
  endtask

  logic [127:0] res;

  initial begin
    m_reset_all();

    // reset state
    repeat (3) @(negedge clk);
    check("reset_key_block", {key, block}, 256'(0));
    check("reset_ctrl", 256'({data_out, out_valid, busy, err, key_full, txt_full, core_start}), 256'(0));
    rst_n = 1'b1;
    tick();

    // directed vector
    for (int i = 0; i < NBYTES; i++) wr(1'b0, 8'(i));
    for (int i = 0; i < NBYTES; i++) wr(1'b1, 8'(i * 8'h11));
    check("key_vector", 256'(key), 256'(128'h000102030405060708090a0b0c0d0e0f));
    check("block_vector", 256'(block), 256'(128'h00112233445566778899aabbccddeeff));
    check("both_full", 256'({key_full, txt_full}), 256'(2'b11));
    do_start();
    run_core(10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    read_all(2);

    // second block with retained key
    load_rand(1'b1, NBYTES);
    do_start();
    run_core($urandom_range(1, 30), {$urandom, $urandom, $urandom, $urandom});
    read_all(3);

    // start with 15 key bytes is ignored; 16th byte then start launches
    do_clr();
    load_rand(1'b0, NBYTES - 1);
    load_rand(1'b1, NBYTES);
    do_start();
    tick();
    check("no_launch_partial_key", 256'({core_start, busy, key_full}), 256'(0));
    load_rand(1'b0, 1);
    do_start();
    run_core($urandom_range(1, 20), {$urandom, $urandom, $urandom, $urandom});
    read_all(1);

    // watchdog expiry, core_done in ERR ignored, clr recovers
    load_rand(1'b1, NBYTES);
    do_start();
    repeat (TIMEOUT) tick();
    check("err_before_timeout", 256'({err, busy}), 256'(2'b01));
    tick();
    check("err_at_timeout", 256'({err, busy, out_valid}), 256'(3'b100));
    core_done = 1'b1; rd_next = 1'b1;
    tick();
    core_done = 1'b0; rd_next = 1'b0;
    check("err_held", 256'({err, out_valid}), 256'(2'b10));
    do_clr();
    check("key_retained_after_clr", {key, block}, {m_key_vec(), m_txt_vec()});

    // clr alongside start with both full: no launch
    load_rand(1'b0, NBYTES);
    load_rand(1'b1, NBYTES);
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    m_clear_flags();
    check("clr_beats_start", 256'({core_start, busy, key_full, txt_full}), 256'(0));

    // core_done on the watchdog cycle wins
    load_rand(1'b0, NBYTES);
    load_rand(1'b1, NBYTES);
    do_start();
    run_core(TIMEOUT, {$urandom, $urandom, $urandom, $urandom});
    check("no_err_on_coincident_done", 256'(err), 256'(0));
    read_all(0);

    // random blocks
    for (int it = 0; it < 4; it++) begin
      if ($urandom_range(0, 1) == 1) load_rand(1'b0, NBYTES);
      load_rand(1'b1, NBYTES);
      do_start();
      run_core($urandom_range(1, 40), {$urandom, $urandom, $urandom, $urandom});
      read_all(2);
    end

    // write+start on the 16th plaintext byte, then reset during OUT byte 7
    load_rand(1'b1, NBYTES - 1);
    wr_start(1'b1, 8'($urandom));
    check("txt_full_after_wr_start", 256'(txt_full), 256'(1));
    do_start();
    run_core($urandom_range(1, 15), {$urandom, $urandom, $urandom, $urandom});
    read_bytes(7, 1);
    check("out_on_byte7", 256'(out_valid), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midout_reset_key_block", {key, block}, 256'(0));
    check("midout_reset_ctrl", 256'({data_out, out_valid, busy, err, key_full, txt_full, core_start}), 256'(0));
    byte_q.delete();
    m_reset_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("flags_after_release", 256'({key_full, txt_full, out_valid, busy}), 256'(0));
    do_start();

    tick();
    check("launch_queue_empty", 256'(launch_q.size()), 256'(0));
    check("byte_queue_empty", 256'(byte_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
